seq_shift_add_multiplier: RTL and testbench
===========================================

// Module: seq_shift_add_multiplier
// PURPOSE
// - Parametrised sequential multiplier: WIDTH x WIDTH -> 2*WIDTH product,
//   computed by shift-and-add at one partial product per clock.
// - Successor to the fixed 2x2 combinational array multiplier. Adds width
//   generality, a signed/unsigned mode and valid/ready handshakes on both sides.
// - Sits between a producer and consumer stage wherever area matters more
//   than throughput.
// PARAMETERS
// - WIDTH  8  operand width in bits (>=2); product is 2*WIDTH bits
// PORTS
// - clk          in   1          single clock, rising edge
// - rst          in   1          synchronous reset, active-high
// - in_valid     in   1          operands a, b, signed_mode are valid
// - in_ready     out  1          block can accept operands (IDLE only)
// - a            in   WIDTH      multiplicand
// - b            in   WIDTH      multiplier
// - signed_mode  in   1          1: a, b two's complement; 0: unsigned
// - out_valid    out  1          product is valid and held
// - out_ready    in   1          consumer accepts product
// - product      out  2*WIDTH    result
// - busy         out  1          state != IDLE
// BEHAVIOUR
// - One clock; reset is synchronous and active-high. rst overrides all
//   other inputs on the same edge.
// - Reset values: state=IDLE, out_valid=0, product=0, busy=0, count=0.
//   in_ready=0 while rst=1, and 1 from the first cycle after rst is released.
// - FSM: IDLE -> CALC on (in_valid && in_ready). CALC -> DONE on the edge
//   that completes step WIDTH-1. DONE -> IDLE on (out_valid && out_ready).
// - Accept edge: latch |a|, |b| as WIDTH-bit magnitudes when signed_mode=1,
//   raw a, b otherwise. Latch neg = signed_mode & (a[MSB] ^ b[MSB]).
//   Clear the accumulator and set count=0.
// - Each CALC edge:
//   - if the multiplier LSB is 1, add the multiplicand into the upper half
//     of the accumulator (carry kept);
//   - shift right by 1;
//   - count++.
// - Final CALC edge: product <= neg ? -acc : acc (2*WIDTH-bit two's
//   complement); out_valid <= 1.
// - Latency: out_valid first high exactly WIDTH cycles after the accept edge.
//   in_ready returns to 1 the cycle after the output handshake.
//   Max throughput is 1 result per WIDTH+2 cycles.
// - Widths:
//   - the magnitude of the most negative operand (-2^(WIDTH-1)) fits in
//     WIDTH unsigned bits;
//   - no overflow is possible;
//   - signed -2^(W-1) * -2^(W-1) = +2^(2W-2) is representable.
// - DONE: product and out_valid stay stable until out_ready=1.
//   in_valid is ignored (in_ready=0) in CALC and DONE.
// - Output handshake edge: out_valid <= 0; product keeps its last value.
// - Zero operand: still takes WIDTH cycles; product=0. Sign correction of
//   zero gives 0, never a negative encoding.
// - Operand inputs may change freely after the accept edge; the latched
//   copies are used.
// - Reset mid-CALC or mid-DONE: result discarded, out_valid=0, product=0,
//   FSM in IDLE after the edge.
// TESTING
// - WIDTH=2, unsigned, a=3, b=3 -> product=4'b1001 after 2 cycles
//   (matches the old 2x2 block).
// - WIDTH=8, unsigned, a=0xFF, b=0xFF -> product=0xFE01, out_valid exactly
//   8 cycles after accept.
// - WIDTH=8, signed: a=-3 (0xFD), b=5 -> 0xFFF1;
//   a=0x80, b=0x80 -> 0x4000; a=0x80, b=0x01 -> 0xFF80.
// - Backpressure: out_ready=0 for 5 cycles in DONE with in_valid=1 ->
//   product stable, in_ready=0, no new accept; out_ready=1 -> IDLE next cycle.
// - rst pulse at CALC step 3 -> next cycle: out_valid=0, product=0,
//   in_ready=1, busy=0. A fresh op of 7*6 then gives 42.
// - WIDTH=4 exhaustive: all 256 pairs x both modes vs a reference model,
//   back-to-back with out_ready=1 -> all match; the result interval is
//   exactly WIDTH+2 cycles.

Source files
------------

// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-and-add multiplier: WIDTH x WIDTH -> 2*WIDTH, one partial
// product per clock, signed or unsigned, valid/ready on both sides.
module seq_shift_add_multiplier #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 signed_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy,
   output logic [1:0]           state_dbg
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   // Handshakes: a transfer happens on a rising edge where valid && ready are
   // both high. in_valid/operands need only be held until that edge; product
   // and out_valid are held stable from out_valid rising until out_ready.

   // state_dbg encoding: 0 = IDLE, 1 = CALC, 2 = DONE.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mier;
   logic [PW-1:0]    acc;
   logic             neg;

   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;
   logic [WIDTH:0]   upper_sum;
   logic [PW-1:0]    acc_next;
   logic [PW-1:0]    result;

   // Magnitudes stay WIDTH bits: |-2^(WIDTH-1)| = 2^(WIDTH-1) still fits unsigned.
   always_comb begin
      mag_a = a;
      mag_b = b;
      if (signed_mode && a[WIDTH-1]) mag_a = ~a + WIDTH'(1);
      if (signed_mode && b[WIDTH-1]) mag_b = ~b + WIDTH'(1);
   end

   // The add carry lands in the top bit after the right shift.
   always_comb begin
      upper_sum = {1'b0, acc[PW-1:WIDTH]} + {1'b0, mcand};
      acc_next  = {1'b0, acc[PW-1:1]};
      if (mier[0]) acc_next = {upper_sum, acc[WIDTH-1:1]};
      result = neg ? (~acc_next + PW'(1)) : acc_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         count     <= '0;
         mcand     <= '0;
         mier      <= '0;
         acc       <= '0;
         neg       <= 1'b0;
         out_valid <= 1'b0;
         product   <= '0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  mcand <= mag_a;
                  mier  <= mag_b;
                  neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                  acc   <= '0;
                  count <= '0;
                  busy  <= 1'b1;
                  state <= CALC;
               end
            end
            CALC: begin
               acc   <= acc_next;
               mier  <= mier >> 1;
               count <= count + CW'(1);
               if (count == LAST_STEP) begin
                  product   <= result;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // busy mirrors state != IDLE; rst gates in_ready so it reads 0 during reset.
   assign in_ready  = ~busy & ~rst;
   assign state_dbg = state;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Bench for seq_shift_add_multiplier at WIDTH = 2, 4 and 8 against an
// integer-arithmetic reference model.
module tb_seq_shift_add_multiplier;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Instance index: 0 -> WIDTH 2, 1 -> WIDTH 4, 2 -> WIDTH 8.
   logic [2:0] in_valid  = '0;
   logic [2:0] out_ready = '1;
   logic [2:0] sm_in     = '0;
   logic [7:0] a_in [3];
   logic [7:0] b_in [3];
   wire  [2:0] in_ready;
   wire  [2:0] out_valid;
   wire  [2:0] busy;
   logic [3:0]  prod2;
   logic [7:0]  prod4;
   logic [15:0] prod8;
   logic [1:0]  st2, st4, st8;

   seq_shift_add_multiplier #(.WIDTH(2)) u_w2 (
      .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .a(a_in[0][1:0]), .b(b_in[0][1:0]), .signed_mode(sm_in[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .product(prod2),
      .busy(busy[0]), .state_dbg(st2));

   seq_shift_add_multiplier #(.WIDTH(4)) u_w4 (
      .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .a(a_in[1][3:0]), .b(b_in[1][3:0]), .signed_mode(sm_in[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .product(prod4),
      .busy(busy[1]), .state_dbg(st4));

   seq_shift_add_multiplier #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .a(a_in[2]), .b(b_in[2]), .signed_mode(sm_in[2]),
      .out_valid(out_valid[2]), .out_ready(out_ready[2]), .product(prod8),
      .busy(busy[2]), .state_dbg(st8));

   int n_checks = 0;
   int n_fail   = 0;
   logic [15:0] exp_q [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int width_of(input int idx);
      return (idx == 0) ? 2 : (idx == 1) ? 4 : 8;
   endfunction

   function automatic logic [15:0] get_prod(input int idx);
      case (idx)
         0:       return {12'd0, prod2};
         1:       return {8'd0, prod4};
         default: return prod8;
      endcase
   endfunction

   function automatic logic [1:0] get_state(input int idx);
      case (idx)
         0:       return st2;
         1:       return st4;
         default: return st8;
      endcase
   endfunction

   // Reference: interpret operands as integers, multiply, keep 2*w bits.
   function automatic logic [15:0] model(input int w, input logic [7:0] av, input logic [7:0] bv,
                                         input logic sm);
      longint x, y, p, mask;
      mask = (longint'(1) << w) - 1;
      x = longint'(av) & mask;
      y = longint'(bv) & mask;
      if (sm && x >= (longint'(1) << (w - 1))) x = x - (longint'(1) << w);
      if (sm && y >= (longint'(1) << (w - 1))) y = y - (longint'(1) << w);
      p = (x * y) & ((longint'(1) << (2 * w)) - 1);
      return p[15:0];
   endfunction

   task automatic wait_ready(input int idx);
      int n = 0;
      while (!in_ready[idx] && n < 50) begin
         step();
         n++;
      end
      check("in_ready_wait", {31'd0, in_ready[idx]}, 32'd1);
   endtask

   task automatic do_op(input int idx, input logic [7:0] av, input logic [7:0] bv,
                        input logic sm, input int hold, output int acc_cyc);
      int w, lat;
      logic [15:0] expv;
      w = width_of(idx);
      wait_ready(idx);
      a_in[idx] = av;
      b_in[idx] = bv;
      sm_in[idx] = sm;
      in_valid[idx] = 1'b1;
      out_ready[idx] = (hold == 0);
      exp_q.push_back(model(w, av, bv, sm));
      step();
      acc_cyc = cyc;
      in_valid[idx] = 1'b0;
      a_in[idx] = 8'($urandom);
      b_in[idx] = 8'($urandom);
      sm_in[idx] = 1'($urandom);
      check("calc_busy", {30'd0, busy[idx], in_ready[idx]}, 32'd2);
      lat = 0;
      while (!out_valid[idx] && lat < 40) begin
         step();
         lat++;
      end
      check("latency", lat, w);
      expv = exp_q.pop_front();
      check("product", {16'd0, get_prod(idx)}, {16'd0, expv});
      for (int k = 0; k < hold; k++) begin
         in_valid[idx] = 1'b1;
         a_in[idx] = 8'($urandom);
         step();
         check("bp_hold", {15'd0, out_valid[idx], in_ready[idx], get_prod(idx)},
               {15'd0, 1'b1, 1'b0, expv});
      end
      in_valid[idx] = 1'b0;
      out_ready[idx] = 1'b1;
      step();
      check("post_hs", {14'd0, out_valid[idx], in_ready[idx], busy[idx], get_prod(idx)},
            {14'd0, 1'b0, 1'b1, 1'b0, expv});
   endtask

   task automatic abort_op(input int idx, input int n_steps);
      wait_ready(idx);
      a_in[idx] = 8'hFF;
      b_in[idx] = 8'hFF;
      sm_in[idx] = 1'b0;
      in_valid[idx] = 1'b1;
      out_ready[idx] = 1'b0;
      step();
      in_valid[idx] = 1'b0;
      repeat (n_steps) step();
      check("abort_pre_valid", {31'd0, out_valid[idx]}, {31'd0, n_steps >= width_of(idx)});
      rst = 1'b1;
      step();
      check("abort_rst", {14'd0, out_valid[idx], busy[idx], in_ready[idx], get_prod(idx)}, 32'd0);
      rst = 1'b0;
      #1;
      check("abort_ready", {31'd0, in_ready[idx]}, 32'd1);
      out_ready[idx] = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t, prev_t;
      for (int i = 0; i < 3; i++) begin
         a_in[i] = '0;
         b_in[i] = '0;
      end
      rst = 1'b1;
      repeat (3) step();
      for (int i = 0; i < 3; i++) begin
         check("reset_outputs", {13'd0, in_ready[i], out_valid[i], busy[i], get_prod(i)}, 32'd0);
         check("reset_state", {30'd0, get_state(i)}, 32'd0);
      end
      rst = 1'b0;
      #1;
      check("ready_after_rst", {29'd0, in_ready}, 32'd7);

      do_op(0, 8'd3, 8'd3, 1'b0, 0, t);
      do_op(2, 8'hFF, 8'hFF, 1'b0, 0, t);
      do_op(2, 8'hFD, 8'h05, 1'b1, 0, t);
      do_op(2, 8'h80, 8'h80, 1'b1, 0, t);
      do_op(2, 8'h80, 8'h01, 1'b1, 0, t);
      do_op(2, 8'h12, 8'h34, 1'b0, 5, t);

      abort_op(2, 3);
      do_op(2, 8'd7, 8'd6, 1'b0, 0, t);
      check("fresh_42", {16'd0, prod8}, 32'd42);
      abort_op(2, 10);

      do_op(2, 8'h00, 8'hFB, 1'b1, 0, t);
      do_op(2, 8'h80, 8'h00, 1'b1, 2, t);
      do_op(1, 8'h00, 8'h00, 1'b1, 0, t);

      prev_t = 0;
      for (int m = 0; m < 2; m++) begin
         for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
               do_op(1, 8'(x), 8'(y), 1'(m), 0, t);
               if (m != 0 || x != 0 || y != 0) check("interval", t - prev_t, 32'd6);
               prev_t = t;
            end
         end
      end

      repeat (60) begin
         do_op($urandom_range(0, 2), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
               $urandom_range(0, 3), t);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
